posit_normalize_encode: RTL
===========================

Name: posit_normalize_encode

Overview:
Pipelined encoder and rounder: the inverse of posit_data_extract. It takes the decoded result fields of an arithmetic unit (sign, NaR, zero, signed scale, fraction beyond the hidden bit, sticky) and produces a correctly rounded posit word. It sits at the tail of posit_adder_full and the multiplier datapaths. It uses the same rts/rtr/sow/eow streaming handshake as those units.

Parameters:
POSIT_WIDTH, 16, posit word width N (>= 4)
POSIT_ES, 0, exponent field width
SCALE_WIDTH, 6, signed scale input width; must hold ±(N-2)·2^ES plus 1 bit headroom
FRAC_IN_WIDTH, 16, fraction input width, hidden bit excluded, MSB-aligned

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
rts_i  in  1  input valid
rtr_o  out  1  ready for input
sow_i  in  1  start-of-window tag, travels with data
eow_i  in  1  end-of-window tag, travels with data
sign_i  in  1  result sign
nar_i  in  1  result is NaR
zero_i  in  1  result is zero
scale_i  in  SCALE_WIDTH  signed scale, two's complement
fraction_i  in  FRAC_IN_WIDTH  fraction bits below hidden 1
sticky_i  in  1  OR of bits already discarded upstream
rts_o  out  1  output valid
rtr_i  in  1  downstream ready
sow_o  out  1  tag aligned with result
eow_o  out  1  tag aligned with result
result  out  POSIT_WIDTH  encoded posit

Behaviour:
- Reset (rst_n=0 at edge): all stage valids cleared; rts_o=0, sow_o=0, eow_o=0, result=0; rtr_o=1 the following cycle. Reset mid-stream drops all in-flight items.
- 3 register stages (S1 capture, S2 regime/body build, S3 round/negate). Latency 3 cycles from accepted input to rts_o when there is no stall.
- Global enable: adv = rtr_i | ~rts_o. rtr_o = adv, combinational. An input is accepted when rts_i & rtr_o.
- When adv=0, every stage holds, including valids, tags and data. result and tags stay stable while rts_o=1 and rtr_i=0.
- Bubbles are allowed in the pipe. Items are never reordered, duplicated or dropped. Tags shift in lockstep with data.
- Encoding:
  - k = scale_i >>> ES (arithmetic shift); e = scale_i[ES-1:0].
  - Regime for k>=0 is (k+1) ones then a 0. Regime for k<0 is (-k) zeros then a 1.
  - Body = regime | e | fraction_i | zeros, truncated to N-1 bits.
  - guard = the next bit after truncation. sticky = OR of all remaining bits | sticky_i.
- Rounding: round-to-nearest-even. Increment the body iff guard & (lsb | sticky).
- Saturation and clamping:
  - k >= N-2 gives maxpos (0 then N-1 ones).
  - k < -(N-2) gives minpos (0…01).
  - A rounded body that would become all zeros gives minpos.
  - Rounding past maxpos clamps to maxpos.
  - Nonzero real values never encode to 0 or NaR.
- Sign: if sign_i, result = two's complement of {0, body}.
- Specials, with precedence nar_i > zero_i > normal:
  - nar_i gives 1 then N-1 zeros.
  - zero_i gives all zeros.
  - sign, scale and fraction are ignored for specials.
- Simultaneous rts_i and downstream stall: rtr_o=0, so the input is not accepted and the source holds.

Decomposition:
- posit_defines package:
  - GET_SCALE_WIDTH / GET_FRACTION_WIDTH macros (shared with the extract side)
  - functions posit_nar(N), posit_maxpos(N), posit_minpos(N)
  - typedef for the decoded-field struct {sign, nar, zero, scale, fraction, sticky}, reused as the S1/S2 payload
- One combinational sub-module, posit_round_rne: body + guard + sticky + sign in, final word out, including the clamp rules. It is reusable by the multiplier.

Test Plan:
- N=16, ES=0, sign=0, scale=0, fraction=0x0000 -> 0x4000 after 3 cycles; sign=1 -> 0xC000.
- Tie handling: scale=0, fraction=0x0004, sticky=0 -> 0x4000 (even kept). fraction=0x000C -> 0x4002. fraction=0x0004, sticky=1 -> 0x4001.
- Saturation: scale=14 -> 0x7FFF; scale=20 -> 0x7FFF; scale=-20 -> 0x0001; scale=-14, fraction=0 -> 0x0001.
- Specials: nar=1, zero=1, scale=3 -> 0x8000; zero=1 -> 0x0000.
- Back-pressure:
  - Stream 4 items with sow on the first and eow on the last, rtr_i=0 from cycle 3 to 8 -> rtr_o low during the stall, result and tags frozen.
  - On release, all 4 come out in order with sow/eow aligned, with no loss or duplication.
- Reset mid-stream: rst_n=0 for one cycle with 2 items in flight -> next cycle rts_o=0, eow_o=0; no stale item emerges afterwards.

Source files
------------

// File: rtl/posit_defines.sv
// Shared posit definitions: field-width helpers, special encodings and the
// decoded-field payload exchanged between the extract and encode sides.
`ifndef POSIT_DEFINES_SV
`define POSIT_DEFINES_SV

`define GET_SCALE_WIDTH(N, ES) ($clog2((N) - 1) + (ES) + 2)
`define GET_FRACTION_WIDTH(N, ES) ((N) - (ES) - 3)

package posit_defines;

    localparam int DEF_POSIT_WIDTH   = 16;
    localparam int DEF_POSIT_ES      = 0;
    localparam int DEF_SCALE_WIDTH   = 6;
    localparam int DEF_FRAC_IN_WIDTH = 16;

    function automatic logic [63:0] posit_nar(input int n);
        return 64'(1) << (n - 1);
    endfunction

    function automatic logic [63:0] posit_maxpos(input int n);
        return (64'(1) << (n - 1)) - 64'(1);
    endfunction

    function automatic logic [63:0] posit_minpos(input int n);
        return 64'(n > 0);
    endfunction

    // Default-width instance of the decoded fields; modules with other
    // widths declare the same layout locally.
    typedef struct packed {
        logic                                sign;
        logic                                nar;
        logic                                zero;
        logic signed [DEF_SCALE_WIDTH-1:0]   scale;
        logic        [DEF_FRAC_IN_WIDTH-1:0] fraction;
        logic                                sticky;
    } posit_fields_t;

endpackage

`endif

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even of a posit body with clamping to [minpos, maxpos],
// followed by sign application. Purely combinational.
module posit_round_rne
    import posit_defines::*;
#(
    parameter int POSIT_WIDTH = 16
) (
    input  logic [POSIT_WIDTH-2:0] body,
    input  logic                   guard,
    input  logic                   sticky,
    input  logic                   sign,
    output logic [POSIT_WIDTH-1:0] word
);

    localparam int N = POSIT_WIDTH;
    localparam logic [63:0] MAXPOS64 = posit_maxpos(N);
    localparam logic [63:0] MINPOS64 = posit_minpos(N);

    logic         inc;
    logic [N-1:0] sum;
    logic [N-2:0] mag;

    always_comb begin
        inc = guard & (body[0] | sticky);
        sum = {1'b0, body} + {{(N-1){1'b0}}, inc};
        mag = sum[N-2:0];
        // Carry out of the body means we rounded past maxpos.
        if (sum[N-1])
            mag = MAXPOS64[N-2:0];
        else if (mag == '0)
            mag = MINPOS64[N-2:0];
        word = sign ? (~{1'b0, mag} + N'(1)) : {1'b0, mag};
    end

endmodule

// File: rtl/posit_normalize_encode.sv
// Three-stage posit encoder: S1 captures decoded fields, S2 builds the
// regime/exponent/fraction body with guard and sticky, S3 rounds and negates.
module posit_normalize_encode
    import posit_defines::*;
#(
    parameter int POSIT_WIDTH   = 16,
    parameter int POSIT_ES      = 0,
    parameter int SCALE_WIDTH   = 6,
    parameter int FRAC_IN_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rts_i,
    output logic                     rtr_o,
    input  logic                     sow_i,
    input  logic                     eow_i,
    input  logic                     sign_i,
    input  logic                     nar_i,
    input  logic                     zero_i,
    input  logic [SCALE_WIDTH-1:0]   scale_i,
    input  logic [FRAC_IN_WIDTH-1:0] fraction_i,
    input  logic                     sticky_i,
    output logic                     rts_o,
    input  logic                     rtr_i,
    output logic                     sow_o,
    output logic                     eow_o,
    output logic [POSIT_WIDTH-1:0]   result
);

    localparam int N      = POSIT_WIDTH;
    localparam int STAGES = 3;
    localparam int TAIL_W = POSIT_ES + FRAC_IN_WIDTH;
    localparam int EXT_W  = N + TAIL_W;
    localparam int SH_W   = $clog2(N);

    localparam logic [63:0] NAR64    = posit_nar(N);
    localparam logic [63:0] MAXPOS64 = posit_maxpos(N);
    localparam logic [63:0] MINPOS64 = posit_minpos(N);

    typedef struct packed {
        logic                            sign;
        logic                            nar;
        logic                            zero;
        logic signed [SCALE_WIDTH-1:0]   scale;
        logic        [FRAC_IN_WIDTH-1:0] fraction;
        logic                            sticky;
    } fields_t;

    logic                adv;
    logic                acc;
    logic [STAGES:1]     vld_pipe;
    logic [STAGES:1]     sow_pipe;
    logic [STAGES:1]     eow_pipe;
    fields_t             s1;
    fields_t             s1_d;

    logic [N-2:0]        s2_body;
    logic                s2_guard;
    logic                s2_sticky;
    logic                s2_sign;
    logic                s2_nar;
    logic                s2_zero;

    logic signed [SCALE_WIDTH-1:0] k;
    int                  k_int;
    int                  run_len;
    logic                fill;
    logic [SH_W-1:0]     sh;
    logic [TAIL_W-1:0]   tail;
    logic [EXT_W-1:0]    ext;
    logic [EXT_W-1:0]    shifted;
    logic [N-2:0]        body_d;
    logic                guard_d;
    logic                sticky_d;

    logic [N-1:0]        rounded;
    logic [N-1:0]        result_d;

    assign adv   = rtr_i | ~rts_o;
    assign rtr_o = adv;
    assign acc   = rts_i & adv;
    assign rts_o = vld_pipe[STAGES];
    assign sow_o = sow_pipe[STAGES];
    assign eow_o = eow_pipe[STAGES];

    assign s1_d = '{sign: sign_i, nar: nar_i, zero: zero_i, scale: scale_i,
                    fraction: fraction_i, sticky: sticky_i};

    if (POSIT_ES > 0) begin : g_exp
        assign tail = {s1.scale[POSIT_ES-1:0], s1.fraction};
    end else begin : g_noexp
        assign tail = s1.fraction;
    end

    assign k = $signed(s1.scale) >>> POSIT_ES;

    // The regime is a run of fill bits closed by one opposite bit. Prefixing
    // N-1 fill bits and shifting left trims the run to its true length.
    always_comb begin
        k_int    = int'(k);
        fill     = ~k[SCALE_WIDTH-1];
        run_len  = fill ? k_int + 2 : 1 - k_int;
        sh       = SH_W'(N - run_len);
        ext      = {{(N-1){fill}}, ~fill, tail};
        shifted  = ext << sh;
        body_d   = shifted[EXT_W-1 -: N-1];
        guard_d  = shifted[EXT_W-N];
        sticky_d = (|shifted[EXT_W-N-1:0]) | s1.sticky;
        if (k_int >= N - 2) begin
            body_d   = MAXPOS64[N-2:0];
            guard_d  = 1'b0;
            sticky_d = 1'b0;
        end else if (k_int < 2 - N) begin
            body_d   = MINPOS64[N-2:0];
            guard_d  = 1'b0;
            sticky_d = 1'b0;
        end
    end

    posit_round_rne #(
        .POSIT_WIDTH(N)
    ) u_round (
        .body  (s2_body),
        .guard (s2_guard),
        .sticky(s2_sticky),
        .sign  (s2_sign),
        .word  (rounded)
    );

    assign result_d = s2_nar  ? NAR64[N-1:0] :
                      s2_zero ? '0           : rounded;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            sow_pipe  <= '0;
            eow_pipe  <= '0;
            s1        <= '0;
            s2_body   <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            s2_sign   <= 1'b0;
            s2_nar    <= 1'b0;
            s2_zero   <= 1'b0;
            result    <= '0;
        end else if (adv) begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], acc};
            sow_pipe  <= {sow_pipe[STAGES-1:1], sow_i & acc};
            eow_pipe  <= {eow_pipe[STAGES-1:1], eow_i & acc};
            s1        <= s1_d;
            s2_body   <= body_d;
            s2_guard  <= guard_d;
            s2_sticky <= sticky_d;
            s2_sign   <= s1.sign;
            s2_nar    <= s1.nar;
            s2_zero   <= s1.zero;
            result    <= result_d;
        end
    end

endmodule
